picorv32_mem_model: RTL and testbench
=====================================

# picorv32_mem_model

Nondeterministic memory responder for the picorv32 native memory interface in the riscv-formal harness. It sits directly downstream of the core's `mem_*` bus in the wrapper and replaces the free `mem_ready`/`mem_rdata` drivers. It gives bounded-latency handshakes without a separate fairness assumption, keeps a byte-accurate shadow of one tracked word so load-after-store consistency is provable, and flags core-side protocol violations on a sticky output.

## Interface
Parameters:
- `MAX_WAIT`, 3: maximum stall cycles in WAIT before `mem_ready` is forced; legal range 0..15.
- `TRACK_ADDR`, 32'h0000_1000: word-aligned address of the shadowed word; bits [1:0] are ignored.
- `SHADOW_INIT`, 32'h0: shadow word value after reset.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  core request valid.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  32  request address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write strobes; 0 means read.
- `stall`  in  1  free (solver-driven) stall request.
- `rand_rdata`  in  32  free data returned for untracked reads.
- `mem_ready`  out  1  handshake response, registered.
- `mem_rdata`  out  32  read data, registered.
- `shadow_word`  out  32  current tracked-word contents.
- `txn_count`  out  16  completed handshakes, saturating at 16'hFFFF.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- Three-state FSM: IDLE, WAIT, RESP. `wait_cnt` is a 4-bit counter.
- IDLE: `mem_ready`=0. When `mem_valid`=1, latch `mem_instr`/`mem_addr`/`mem_wdata`/`mem_wstrb`, clear `wait_cnt`, and go to WAIT.
- WAIT: if `stall`=0 or `wait_cnt`==`MAX_WAIT`, register the response and go to RESP. Otherwise increment `wait_cnt`.
- Response registered on leaving WAIT:
  - `mem_ready`<=1.
  - `mem_rdata`<= `shadow_word` if the latched addr[31:2]==`TRACK_ADDR`[31:2] and wstrb==0.
  - Otherwise, if wstrb==0, `mem_rdata`<=`rand_rdata`.
  - Otherwise (write), `mem_rdata`<=32'h0.
- RESP: `mem_ready`=1 for exactly one cycle; this is the handshake cycle.
  - For a write to the tracked word, merge `wdata` into `shadow_word` byte by byte per strobe at the end of RESP.
  - `txn_count` increments (saturating).
  - Next state is IDLE with `mem_ready`<=0.
- Protocol checks set `proto_err`; it stays set until reset.
  - In WAIT or RESP: `mem_valid`=0, or any of instr/addr/wdata/wstrb differs from the latched value.
  - On request acceptance in IDLE, the following are errors:
    - a wstrb outside {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111};
    - `mem_instr`=1 with nonzero wstrb;
    - a misaligned address: addr[0]=1 for a halfword wstrb, or addr[1:0]!=0 for wstrb 1111.
- After `proto_err` sets, handshakes continue normally; the flag never blocks the FSM.

## Timing
- Reset (synchronous, takes priority over all else) forces:
  - FSM=IDLE, `mem_ready`=0, `mem_rdata`=0;
  - `shadow_word`=`SHADOW_INIT`, `txn_count`=0, `proto_err`=0, `wait_cnt`=0.
- Reset mid-transaction abandons the request: no shadow update, no count increment.
- Latency: `mem_valid` rises at cycle t, WAIT at t+1, earliest `mem_ready` at t+2, latest at t+2+`MAX_WAIT`.
- With `MAX_WAIT`=0, `stall` is ignored and latency is fixed at 2.
- Back-to-back: the cycle after RESP is IDLE. A request still asserted there is accepted as new, so minimum request-to-request spacing is 3 cycles.
- Store then load to the tracked word: the load sampling IDLE at RESP+1 or later returns the merged value.
- `shadow_word` output reflects the register, so the update is visible the cycle after RESP.
- `proto_err` sets the cycle after the offending sample.

## Test plan
- Reset, then a read of 0x1000 with `stall`=0 → `mem_ready`=1 exactly at t+2 with `mem_rdata`=0x00000000; `txn_count`=1.
- Write 0x1000 wdata=0xAABBCCDD wstrb=1111, then write 0x1001 wdata=0x00001100 wstrb=0010, then read 0x1000 → read returns 0xAABB11DD.
- Read 0x2000 with `stall` held 1 and `MAX_WAIT`=3 → `mem_ready` at t+5; `mem_rdata` equals `rand_rdata` sampled at t+4.
- Change `mem_addr` from 0x2000 to 0x2004 during WAIT → `proto_err`=1 the next cycle and stays 1; the handshake still completes.
- Issue wstrb=0101, then separately `mem_instr`=1 with wstrb=0001 → `proto_err` asserts on each case (check from reset independently).
- Assert `reset` in WAIT of a write to 0x1000 → next cycle FSM=IDLE, `mem_ready`=0, `shadow_word`=`SHADOW_INIT`, `txn_count`=0.

Source files
------------

// File: rtl/picorv32_mem_model.sv
// Bounded-latency nondeterministic responder for the picorv32 native memory bus.
// Keeps a byte-accurate shadow of one tracked word and flags core protocol errors.
module picorv32_mem_model #(
  parameter int unsigned MAX_WAIT    = 3,
  parameter logic [31:0] TRACK_ADDR  = 32'h0000_1000,
  parameter logic [31:0] SHADOW_INIT = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        stall,
  input  logic [31:0] rand_rdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] shadow_word,
  output logic [15:0] txn_count,
  output logic        proto_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] shadow_q, shadow_d;
  logic [15:0] txn_q, txn_d;
  logic        err_q, err_d;

  logic strb_ok;
  logic misalign;
  logic req_bad;
  logic hold_bad;
  logic hit;

  always_comb begin
    strb_ok = 1'b0;
    case (mem_wstrb)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
      default: strb_ok = 1'b0;
    endcase
  end

  assign misalign =
    ((mem_wstrb == 4'b0011 || mem_wstrb == 4'b1100) && mem_addr[0]) ||
    (mem_wstrb == 4'b1111 && mem_addr[1:0] != 2'b00);

  assign req_bad = !strb_ok || (mem_instr && mem_wstrb != 4'b0000) || misalign;

  // Core must hold the request stable until the handshake cycle.
  assign hold_bad = !mem_valid ||
                    mem_instr != instr_q ||
                    mem_addr  != addr_q  ||
                    mem_wdata != wdata_q ||
                    mem_wstrb != wstrb_q;

  assign hit = addr_q[31:2] == TRACK_ADDR[31:2];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    shadow_d   = shadow_q;
    txn_d      = txn_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (mem_valid) begin
          instr_d    = mem_instr;
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wstrb_d    = mem_wstrb;
          wait_cnt_d = 4'd0;
          state_d    = S_WAIT;
          if (req_bad) err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (hold_bad) err_d = 1'b1;
        if (!stall || wait_cnt_q == MAX_CNT) begin
          ready_d = 1'b1;
          state_d = S_RESP;
          if (wstrb_q != 4'b0000) rdata_d = 32'h0;
          else if (hit)           rdata_d = shadow_q;
          else                    rdata_d = rand_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (hold_bad) err_d = 1'b1;
        if (hit) begin
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) shadow_d[8*b +: 8] = wdata_q[8*b +: 8];
        end
        if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      instr_q    <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'h0;
      shadow_q   <= SHADOW_INIT;
      txn_q      <= 16'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      shadow_q   <= shadow_d;
      txn_q      <= txn_d;
      err_q      <= err_d;
    end
  end

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign shadow_word = shadow_q;
  assign txn_count   = txn_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Randomized self-checking bench for picorv32_mem_model against a
// transaction-level model of latency, shadow merging and protocol rules.
module tb_picorv32_mem_model;

  localparam int MAXW = 3;
  localparam logic [31:0] TRACK = 32'h0000_1000;
  localparam logic [31:0] SINIT = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        stall = 1'b0;
  logic [31:0] rand_rdata = 32'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] shadow_word;
  logic [15:0] txn_count;
  logic        proto_err;

  int total = 0;
  int bad = 0;

  logic [31:0] shadow_m;
  int          txn_m;
  logic        stall_log[$];
  logic [31:0] rand_log[$];

  picorv32_mem_model #(
    .MAX_WAIT(MAXW), .TRACK_ADDR(TRACK), .SHADOW_INIT(SINIT)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall(stall), .rand_rdata(rand_rdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .shadow_word(shadow_word), .txn_count(txn_count),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Index of the WAIT cycle that produces the response.
  function automatic int resp_idx();
    for (int k = 0; k < stall_log.size(); k++)
      if (!stall_log[k] || k == MAXW) return k;
    return MAXW;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; mem_valid = 1'b0; stall = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    shadow_m = SINIT;
    txn_m = 0;
  endtask

  // smode: 0 never stall, 1 always stall, 2 random stall
  task automatic run_txn(input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int smode, output int lat,
                         output logic [31:0] rd);
    stall_log.delete();
    rand_log.delete();
    lat = 0;
    rd = 32'hDEAD_BEEF;
    @(negedge clock);
    mem_valid = 1'b1; mem_instr = ins; mem_addr = a;
    mem_wdata = wd; mem_wstrb = ws; stall = 1'b0;
    @(posedge clock);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (mem_ready) begin
        lat = n;
        rd = mem_rdata;
        break;
      end
      stall = (smode == 0) ? 1'b0 :
              (smode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_rdata = $urandom;
      stall_log.push_back(stall);
      rand_log.push_back(rand_rdata);
    end
    @(posedge clock);
    @(negedge clock);
    mem_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", mem_ready); end
    if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", mem_rdata); end
    if (shadow_word !== SINIT) begin bad++; $display("FAIL reset_shadow got=%h want=%h", shadow_word, SINIT); end
    if (txn_count !== 16'd0) begin bad++; $display("FAIL reset_txn got=%0d want=0", txn_count); end
    if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", proto_err); end
  endtask

  task automatic test_first_read();
    int lat; logic [31:0] rd;
    run_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, lat, rd);
    txn_m++;
    total += 3;
    if (lat != 2) begin bad++; $display("FAIL first_lat got=%0d want=2", lat); end
    if (rd !== shadow_m) begin bad++; $display("FAIL first_rdata got=%h want=%h", rd, shadow_m); end
    if (txn_count !== 16'(txn_m)) begin bad++; $display("FAIL first_txn got=%0d want=%0d", txn_count, txn_m); end
  endtask

  task automatic test_tracked_rw();
    int lat; logic [31:0] rd;
    run_txn(1'b0, 32'h1000, 32'hAABBCCDD, 4'b1111, 0, lat, rd);
    shadow_m = merge(shadow_m, 32'hAABBCCDD, 4'b1111); txn_m++;
    total += 2;
    if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want=0", rd); end
    if (shadow_word !== shadow_m) begin bad++; $display("FAIL wr_shadow got=%h want=%h", shadow_word, shadow_m); end
    run_txn(1'b0, 32'h1001, 32'h00001100, 4'b0010, 0, lat, rd);
    shadow_m = merge(shadow_m, 32'h00001100, 4'b0010); txn_m++;
    run_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, lat, rd);
    txn_m++;
    total += 4;
    if (rd !== 32'hAABB11DD) begin bad++; $display("FAIL rw_rdata got=%h want=aabb11dd", rd); end
    if (shadow_word !== shadow_m) begin bad++; $display("FAIL rw_shadow got=%h want=%h", shadow_word, shadow_m); end
    if (txn_count !== 16'(txn_m)) begin bad++; $display("FAIL rw_txn got=%0d want=%0d", txn_count, txn_m); end
    if (proto_err !== 1'b0) begin bad++; $display("FAIL rw_err got=%b want=0", proto_err); end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] rd;
    run_txn(1'b0, 32'h2000, 32'h0, 4'h0, 1, lat, rd);
    txn_m++;
    total += 2;
    if (lat != MAXW + 2) begin bad++; $display("FAIL stall_lat got=%0d want=%0d", lat, MAXW + 2); end
    if (rd !== rand_log[MAXW]) begin bad++; $display("FAIL stall_rdata got=%h want=%h", rd, rand_log[MAXW]); end
  endtask

  task automatic test_addr_change();
    logic seen;
    do_reset();
    @(negedge clock);
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h2000;
    mem_wdata = 32'h0; mem_wstrb = 4'h0; stall = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_addr = 32'h2004;
    @(negedge clock);
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL chg_err_set got=%b want=1", proto_err); end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_ready) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    @(posedge clock);
    @(negedge clock);
    mem_valid = 1'b0; stall = 1'b0;
    @(negedge clock);
    total += 3;
    if (seen !== 1'b1) begin bad++; $display("FAIL chg_ready got=%b want=1", seen); end
    if (proto_err !== 1'b1) begin bad++; $display("FAIL chg_err_sticky got=%b want=1", proto_err); end
    if (txn_count !== 16'd1) begin bad++; $display("FAIL chg_txn got=%0d want=1", txn_count); end
  endtask

  task automatic test_bad_req();
    int lat; logic [31:0] rd;
    do_reset();
    run_txn(1'b0, 32'h2000, 32'h12345678, 4'b0101, 0, lat, rd);
    total += 2;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL strb_err got=%b want=1", proto_err); end
    if (lat != 2) begin bad++; $display("FAIL strb_lat got=%0d want=2", lat); end
    do_reset();
    run_txn(1'b1, 32'h2000, 32'h0, 4'b0001, 0, lat, rd);
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL instr_err got=%b want=1", proto_err); end
    do_reset();
    run_txn(1'b0, 32'h2002, 32'h0, 4'b1111, 0, lat, rd);
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL align_err got=%b want=1", proto_err); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd;
    do_reset();
    run_txn(1'b0, 32'h1000, 32'h55667788, 4'b1111, 0, lat, rd);
    @(negedge clock);
    mem_valid = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'h01020304;
    mem_wstrb = 4'b1111; mem_instr = 1'b0; stall = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total += 4;
    if (mem_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b want=0", mem_ready); end
    if (shadow_word !== SINIT) begin bad++; $display("FAIL rmid_shadow got=%h want=%h", shadow_word, SINIT); end
    if (txn_count !== 16'd0) begin bad++; $display("FAIL rmid_txn got=%0d want=0", txn_count); end
    if (proto_err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", proto_err); end
    reset = 1'b0; mem_valid = 1'b0; stall = 1'b0;
    shadow_m = SINIT; txn_m = 0;
    @(negedge clock);
  endtask

  task automatic test_random();
    int lat, ri, exp_lat; logic [31:0] rd, a, wd, exp_rd;
    logic [3:0] ws;
    logic [3:0] legal [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    do_reset();
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 1) == 0) ? (TRACK | 32'($urandom_range(0, 3)))
                                      : $urandom;
      ws = legal[$urandom_range(0, 7)];
      if (ws == 4'hF) a[1:0] = 2'b00;
      if (ws == 4'h3 || ws == 4'hC) a[0] = 1'b0;
      wd = $urandom;
      run_txn(1'b0, a, wd, ws, 2, lat, rd);
      ri = resp_idx();
      exp_lat = ri + 2;
      if (ws != 4'h0) exp_rd = 32'h0;
      else if (a[31:2] == TRACK[31:2]) exp_rd = shadow_m;
      else exp_rd = rand_log[ri];
      if (a[31:2] == TRACK[31:2]) shadow_m = merge(shadow_m, wd, ws);
      txn_m++;
      total += 5;
      if (lat != exp_lat) begin bad++; $display("FAIL rnd_lat t=%0d got=%0d want=%0d", t, lat, exp_lat); end
      if (rd !== exp_rd) begin bad++; $display("FAIL rnd_rdata t=%0d got=%h want=%h", t, rd, exp_rd); end
      if (shadow_word !== shadow_m) begin bad++; $display("FAIL rnd_shadow t=%0d got=%h want=%h", t, shadow_word, shadow_m); end
      if (txn_count !== 16'(txn_m)) begin bad++; $display("FAIL rnd_txn t=%0d got=%0d want=%0d", t, txn_count, txn_m); end
      if (proto_err !== 1'b0) begin bad++; $display("FAIL rnd_err t=%0d got=%b want=0", t, proto_err); end
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_tracked_rw();
    test_stall();
    test_addr_change();
    test_bad_req();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
